// File: rtl/sony_block_sync_encoder.sv
// Sony block camera embedded-sync transmitter.
// Turns an upstream 16-bit pixel-pair source into a framed word stream:
// FS header, per-line LS header + pixels + horizontal filler, FE header,
// vertical filler. Pixel bytes are clamped so they can never look like a
// header preamble to the receiver.
module sony_block_sync_encoder #(
    parameter int LINE_WORDS   = 1920,
    parameter int ACTIVE_LINES = 1080,
    parameter int HBLANK_WORDS = 280,
    parameter int VBLANK_WORDS = 2000
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [15:0] data_out,
    output logic        frame_active,
    output logic        line_active,
    output logic        underrun,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        IDLE,
        FS_HDR,
        LS_HDR,
        ACTIVE,
        HBLANK,
        FE_HDR,
        VBLANK
    } state_t;

    localparam logic [15:0] BLANK_WORD    = 16'h1080;
    localparam logic [7:0]  CODE_FS       = 8'h9D;
    localparam logic [7:0]  CODE_LS       = 8'h80;
    localparam logic [7:0]  CODE_FE       = 8'hAB;
    localparam logic [12:0] HDR_LAST      = 13'd3;
    localparam logic [12:0] LINE_LAST     = 13'(LINE_WORDS - 1);
    localparam logic [12:0] HBLANK_LAST   = 13'(HBLANK_WORDS - 1);
    localparam logic [12:0] VBLANK_LAST   = 13'(VBLANK_WORDS - 1);
    localparam logic [10:0] LINE_CNT_LAST = 11'(ACTIVE_LINES - 1);

    state_t      state;
    state_t      state_next;
    logic [12:0] wcnt;
    logic [10:0] lcnt;
    logic        last_word;
    logic        enable_q;

    logic [15:0] data_d;
    logic        frame_active_d;
    logic        line_active_d;
    logic        underrun_d;
    logic [15:0] frame_count_d;

    // Keep pixel bytes out of the reserved 00/FF codes used by headers.
    function automatic logic [7:0] clamp_byte(input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (b == 8'hFF) r = 8'hFE;
        if (b == 8'h00) r = 8'h01;
        return r;
    endfunction

    // Four-word header: preamble FFFF 0000 0000 followed by the code word.
    function automatic logic [15:0] hdr_word(input logic [7:0] code, input logic [1:0] idx);
        logic [15:0] w;
        case (idx)
            2'd0:    w = 16'hFFFF;
            2'd3:    w = {8'h00, code};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Flags the final word of the current state's fixed-length run.
    always_comb begin
        last_word = 1'b0;
        case (state)
            FS_HDR, LS_HDR, FE_HDR: last_word = (wcnt == HDR_LAST);
            ACTIVE:                 last_word = (wcnt == LINE_LAST);
            HBLANK:                 last_word = (wcnt == HBLANK_LAST);
            VBLANK:                 last_word = (wcnt == VBLANK_LAST);
            default:                last_word = 1'b0;
        endcase
    end

    // Registered enable gives the two-edge start latency and a clean sample point.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) enable_q <= 1'b0;
        else          enable_q <= enable;
    end

    // State register.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic; enable only matters in IDLE and at the end of VBLANK.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable_q) state_next = FS_HDR;
            FS_HDR:  if (last_word) state_next = LS_HDR;
            LS_HDR:  if (last_word) state_next = ACTIVE;
            ACTIVE:  if (last_word) state_next = HBLANK;
            HBLANK:  if (last_word) state_next = (lcnt == LINE_CNT_LAST) ? FE_HDR : LS_HDR;
            FE_HDR:  if (last_word) state_next = VBLANK;
            VBLANK:  if (last_word) state_next = enable_q ? FS_HDR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Word counter restarts per state run; line counter restarts each frame.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            wcnt <= '0;
            lcnt <= '0;
        end else begin
            if (last_word || state == IDLE) wcnt <= '0;
            else                            wcnt <= wcnt + 13'd1;
            if (state == FS_HDR)                    lcnt <= '0;
            else if (state == HBLANK && last_word)  lcnt <= lcnt + 11'd1;
        end
    end

    // Next output word and qualifiers derived from the current state.
    always_comb begin
        data_d         = BLANK_WORD;
        frame_active_d = 1'b0;
        line_active_d  = 1'b0;
        underrun_d     = 1'b0;
        frame_count_d  = frame_count;
        case (state)
            FS_HDR: begin
                data_d         = hdr_word(CODE_FS, wcnt[1:0]);
                frame_active_d = 1'b1;
            end
            LS_HDR: begin
                data_d         = hdr_word(CODE_LS, wcnt[1:0]);
                frame_active_d = 1'b1;
            end
            ACTIVE: begin
                frame_active_d = 1'b1;
                line_active_d  = 1'b1;
                if (pix_valid) data_d = {clamp_byte(pix_data[15:8]), clamp_byte(pix_data[7:0])};
                else           underrun_d = 1'b1;
            end
            HBLANK: frame_active_d = 1'b1;
            FE_HDR: begin
                data_d         = hdr_word(CODE_FE, wcnt[1:0]);
                frame_active_d = 1'b1;
                if (last_word) frame_count_d = frame_count + 16'd1;
            end
            default: data_d = BLANK_WORD;
        endcase
    end

    // Output register stage.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            data_out     <= BLANK_WORD;
            frame_active <= 1'b0;
            line_active  <= 1'b0;
            underrun     <= 1'b0;
            frame_count  <= '0;
        end else begin
            data_out     <= data_d;
            frame_active <= frame_active_d;
            line_active  <= line_active_d;
            underrun     <= underrun_d;
            frame_count  <= frame_count_d;
        end
    end

    assign pix_ready = (state == ACTIVE);

endmodule

// File: doc/sony_block_sync_encoder.md
# sony_block_sync_encoder

Transmit-side counterpart of the Sony block camera parallel interface. It generates a 16-bit embedded-sync word stream (frame-start, line-start and frame-end headers, active pixels, blanking) from an upstream YUV422 8-bit pixel-pair source. A receiver that splits each word into two bytes and decodes the headers recovers FV/LV and 3840-byte lines. Used as camera emulator / loopback source for the CSI-2 bridge and as a bench stimulus generator.

## Interface
- LINE_WORDS, 1920, active 16-bit words per line (2 bytes each; 1920 → 3840 bytes)
- ACTIVE_LINES, 1080, active lines per frame
- HBLANK_WORDS, 280, filler words after each line's pixels (≥1)
- VBLANK_WORDS, 2000, filler words after frame-end header (≥1)
- clock_in  input  1  word clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  start/continue frames; sampled in IDLE and at end of VBLANK
- pix_data  input  16  pixel pair; [15:8] is the earlier byte on the wire
- pix_valid  input  1  pix_data valid
- pix_ready  output  1  combinational; high only while state = ACTIVE
- data_out  output  16  encoded stream, registered; [15:8] transmitted first
- frame_active  output  1  registered; high on every data_out word from first FS header word to last FE header word
- line_active  output  1  registered; high on exactly the pixel words of data_out
- underrun  output  1  registered 1-cycle pulse: pixel slot filled with blank
- frame_count  output  16  registered; count of completed frames (FE header sent), wraps 0xFFFF→0

## Operation
- Header = 4 words: 16'hFFFF, 16'h0000, 16'h0000, {8'h00, CODE}. CODE: 8'h9D frame start (FS), 8'h80 line start (LS), 8'hAB frame end (FE).
- Blank/filler word = 16'h1080 (YUV black).
- States: IDLE, FS_HDR, LS_HDR, ACTIVE, HBLANK, FE_HDR, VBLANK. Word counter wcnt (13 bit), line counter lcnt (11 bit).
- IDLE: emit blank; enable=1 → FS_HDR.
- FS_HDR: 4 words → LS_HDR (lcnt=0).
- LS_HDR: 4 words → ACTIVE.
- ACTIVE: LINE_WORDS words → HBLANK. Each word: if pix_valid, emit clamped pix_data (word consumed); else emit blank, pulse underrun. The word counter advances regardless (line length is fixed; no stall).
- Clamp per byte: 8'hFF→8'hFE, 8'h00→8'h01; other values pass unchanged. No header pattern can appear in pixel data.
- HBLANK: HBLANK_WORDS blanks; then lcnt==ACTIVE_LINES-1 → FE_HDR, else lcnt+1 → LS_HDR.
- FE_HDR: 4 words; frame_count+1 on the last word → VBLANK.
- VBLANK: VBLANK_WORDS blanks; then enable=1 → FS_HDR, else IDLE.
- enable deasserted mid-frame: ignored until end of VBLANK; a frame is never truncated.
- Reset mid-frame: immediate return to IDLE, counters cleared. No FE header is sent.

## Timing
- Reset values: data_out=16'h1080, frame_active=0, line_active=0, underrun=0, frame_count=0, state IDLE. pix_ready=0 in reset.
- enable sampled high at edge k in IDLE → first FS word (16'hFFFF) on data_out after edge k+2.
- Accepted pix_data (pix_valid & pix_ready at edge k) appears clamped on data_out after edge k; line_active and underrun align with that word.
- Frame length in words = 8 + ACTIVE_LINES·(4+LINE_WORDS+HBLANK_WORDS) + VBLANK_WORDS. Back-to-back frames need no gap beyond VBLANK.
- frame_active goes low on the first VBLANK word.

## Test plan
- Params 4/2/2/3. Reset, then hold enable=1, pix_valid=1, pix_data incrementing from 16'h0102 -> stream is FFFF,0000,0000,009D, then 2×[FFFF,0000,0000,0080, 4 pixels, 1080,1080], then FFFF,0000,0000,00AB, 1080×3, then the next FS header. 31-word period; frame_count 1 after the first FE.
- pix_data=16'hFF00 → data_out 16'hFE01; pix_data 16'h00FF → 16'h01FE.
- pix_valid=0 on the 3rd pixel slot of line 0 -> data_out 16'h1080, underrun pulse on that word only, line_active stays high, line still 4 words.
- Drop enable during line 1 -> frame completes with FE and VBLANK, then the block returns to IDLE with blanks and no new FS; reassert enable -> FS starts 2 edges later.
- Assert reset_n=0 mid-ACTIVE asynchronously -> data_out=1080, frame_active=0, line_active=0 immediately. After release with enable=1, a fresh FS header; frame_count=0.
- Byte-split loopback into the receiver (upper byte first) -> FV/LV recovered, 8 bytes per LS line at these params, no false header detection with random clamped data.
